imem_loader: RTL and testbench

Boot-time program loader and memory-port owner for the multicycle RISC-V core. It receives a byte stream from a UART receiver and assembles little-endian 32-bit words. It writes those words into unified memory through the single memory port while holding the core in reset, then releases the core and hands the port over. The block sits between the core's memory interface and the memory, so it configures and sequences the core.

---
 rtl/loader_pkg.sv | 30 +++
 rtl/loader_word_asm.sv | 57 +++++
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// ============================================================================
// Module : loader_pkg
// Brief  : Shared types and constants for the imem_loader boot loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam int BYTE_CNT_W = 2;
    localparam int LEN_W      = 16;

    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [2:0] {
        ST_LEN0 = 3'd0,
        ST_LEN1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    function automatic logic [31:0] next_word_addr(input logic [31:0] adr);
        return adr + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/loader_word_asm.sv
// ============================================================================
// Module : loader_word_asm
// Brief  : Assembles four bytes into a little-endian 32-bit word and emits a
//          one-cycle registered word_valid pulse after the fourth byte.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module loader_word_asm
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [BYTE_CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]           shreg_q, shreg_d;
    logic                  wvld_q,  wvld_d;

    // Shifting in from the top leaves the first byte in [7:0] after four bytes.
    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        wvld_d  = 1'b0;
        if (clear_i) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (byte_valid_i) begin
            shreg_d = {byte_data_i, shreg_q[31:8]};
            cnt_d   = cnt_q + 1'b1;
            wvld_d  = (cnt_q == '1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            wvld_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            wvld_q  <= wvld_d;
        end
    end

    assign word_valid_o = wvld_q;
    assign word_o       = shreg_q;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Brief  : Boot loader that streams a UART frame into memory while holding the
//          core in reset, then hands the memory port to the core.
//          Optional trailing XOR checksum: define LOADER_CHECKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        reload,
    input  logic [31:0] core_adr,
    input  logic        core_we,
    input  logic [31:0] core_wdata,
    output logic [31:0] mem_adr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        err
);

    state_e      state_q, state_d;
    len_t        len_q,   len_d;
    len_t        idx_q,   idx_d;
    logic [31:0] adr_q,   adr_d;

    logic        w_accept;
    logic        w_reload_take;
    logic        w_word_valid;
    logic [31:0] w_word;
    logic        w_last_word;
    logic        w_final_pulse;
    logic        w_data_byte;
    len_t        w_len_full;

    assign w_accept      = rx_valid && rx_ready;
    assign w_reload_take = reload && ((state_q == ST_RUN) || (state_q == ST_ERR));
    assign w_len_full    = {rx_data, len_q[7:0]};
    assign w_last_word   = (idx_q == (len_q - 16'd1));
    assign w_final_pulse = (state_q == ST_DATA) && w_word_valid && w_last_word;
    // A byte arriving alongside the final write pulse is not data: it is the
    // checksum (or a stray byte that is dropped).
    assign w_data_byte   = w_accept && (state_q == ST_DATA) && !w_final_pulse;

    loader_word_asm u_word_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (w_reload_take),
        .byte_valid_i (w_data_byte),
        .byte_data_i  (rx_data),
        .word_valid_o (w_word_valid),
        .word_o       (w_word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (w_reload_take) begin
            chk_d = '0;
        end else if (w_accept && ((state_q == ST_LEN0) || (state_q == ST_LEN1) || w_data_byte)) begin
            chk_d = chk_q ^ rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) chk_q <= '0;
        else       chk_q <= chk_d;
    end
`endif

    always_comb begin
        len_d = len_q;
        idx_d = idx_q;
        adr_d = adr_q;
        if (w_accept && (state_q == ST_LEN0)) len_d = {8'h00, rx_data};
        if (w_accept && (state_q == ST_LEN1)) len_d = w_len_full;
        if (w_reload_take) begin
            idx_d = '0;
            adr_d = BASE_ADDR;
        end else if (w_word_valid) begin
            idx_d = idx_q + 16'd1;
            adr_d = next_word_addr(adr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LEN0;
            len_q   <= '0;
            idx_q   <= '0;
            adr_q   <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            adr_q   <= adr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LEN0: if (w_accept) state_d = ST_LEN1;
            ST_LEN1: begin
                if (w_accept) begin
                    if ({16'h0000, w_len_full} > DEPTH_WORDS) begin
                        state_d = ST_ERR;
                    end else if (w_len_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_RUN;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_final_pulse) begin
`ifdef LOADER_CHECKSUM_EN
                    if (w_accept) state_d = (rx_data == chk_q) ? ST_RUN : ST_ERR;
                    else          state_d = ST_CHK;
`else
                    state_d = ST_RUN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: if (w_accept) state_d = (rx_data == chk_q) ? ST_RUN : ST_ERR;
`endif
            ST_RUN:  if (reload) state_d = ST_LEN0;
            ST_ERR:  if (reload) state_d = ST_LEN0;
            default: state_d = ST_LEN0;
        endcase
    end

    always_comb begin
        rx_ready   = (state_q != ST_RUN) && (state_q != ST_ERR);
        core_reset = (state_q != ST_RUN);
        done       = (state_q == ST_RUN);
        err        = (state_q == ST_ERR);
        if (state_q == ST_RUN) begin
            mem_adr   = core_adr;
            mem_we    = core_we;
            mem_wdata = core_wdata;
        end else begin
            mem_adr   = adr_q;
            mem_we    = w_word_valid;
            mem_wdata = w_word;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module : tb_imem_loader
// Brief  : Directed self-checking bench for imem_loader (frames, overflow,
//          pass-through, reload, mid-load reset, optional checksum).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic [31:0] core_adr;
    logic        core_we;
    logic [31:0] core_wdata;
    logic [31:0] mem_adr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        core_reset;
    logic        done;
    logic        err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    int          wr_cyc[$];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .core_adr   (core_adr),
        .core_we    (core_we),
        .core_wdata (core_wdata),
        .mem_adr    (mem_adr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Loader-owned writes only (core held in reset).
    always @(negedge clk) begin
        if (mem_we && core_reset) begin
            wr_adr.push_back(mem_adr);
            wr_dat.push_back(mem_wdata);
            wr_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
        wr_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_cnt++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready got=%b exp=1", rx_ready); else pass_cnt++;
        total_cnt++; if (core_reset !== 1'b1) $display("FAIL reset_core_reset got=%b exp=1", core_reset); else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we got=%b exp=0", mem_we); else pass_cnt++;
        total_cnt++; if (mem_adr !== 32'h0) $display("FAIL reset_mem_adr got=%h exp=00000000", mem_adr); else pass_cnt++;
        total_cnt++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got=%h exp=00000000", mem_wdata); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass_cnt++;
    endtask

    task automatic test_two_words();
        logic [7:0] frame[$];
        int n;
        int done_cyc;
        frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        frame.push_back(8'h7E);
`endif
        clear_log();
        foreach (frame[k]) send(frame[k]);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        repeat (2) @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL two_done got=%b exp=1", done); else pass_cnt++;
        total_cnt++; if (core_reset !== 1'b0) $display("FAIL two_core_reset got=%b exp=0", core_reset); else pass_cnt++;
        total_cnt++; if (rx_ready !== 1'b0) $display("FAIL two_rx_ready got=%b exp=0", rx_ready); else pass_cnt++;
        total_cnt++; if (wr_adr.size() != 2) $display("FAIL two_write_count got=%0d exp=2", wr_adr.size()); else pass_cnt++;
        if (wr_adr.size() == 2) begin
            total_cnt++; if (wr_adr[0] !== 32'h0) $display("FAIL two_w0_adr got=%h exp=00000000", wr_adr[0]); else pass_cnt++;
            total_cnt++; if (wr_dat[0] !== 32'h0000_0013) $display("FAIL two_w0_data got=%h exp=00000013", wr_dat[0]); else pass_cnt++;
            total_cnt++; if (wr_adr[1] !== 32'h4) $display("FAIL two_w1_adr got=%h exp=00000004", wr_adr[1]); else pass_cnt++;
            total_cnt++; if (wr_dat[1] !== 32'h0000_006F) $display("FAIL two_w1_data got=%h exp=0000006f", wr_dat[1]); else pass_cnt++;
            total_cnt++; if (done_cyc - wr_cyc[1] != 1) $display("FAIL two_run_latency got=%0d exp=1", done_cyc - wr_cyc[1]); else pass_cnt++;
        end
    endtask

    task automatic test_passthrough();
        core_adr   = 32'h0000_0100;
        core_we    = 1'b1;
        core_wdata = 32'hA5A5_A5A5;
        #1;
        total_cnt++; if (mem_adr !== 32'h0000_0100) $display("FAIL pass_adr got=%h exp=00000100", mem_adr); else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b1) $display("FAIL pass_we got=%b exp=1", mem_we); else pass_cnt++;
        total_cnt++; if (mem_wdata !== 32'hA5A5_A5A5) $display("FAIL pass_wdata got=%h exp=a5a5a5a5", mem_wdata); else pass_cnt++;
        @(negedge clk);
        send(8'h55);
        send(8'h00);
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL pass_rx_ignored_done got=%b exp=1", done); else pass_cnt++;
        total_cnt++; if (rx_ready !== 1'b0) $display("FAIL pass_rx_ready got=%b exp=0", rx_ready); else pass_cnt++;
    endtask

    task automatic test_reload_zero();
        int n;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        total_cnt++; if (core_reset !== 1'b1) $display("FAIL reload_core_reset got=%b exp=1", core_reset); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reload_done got=%b exp=0", done); else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL reload_mem_we got=%b exp=0", mem_we); else pass_cnt++;
        total_cnt++; if (mem_adr !== 32'h0) $display("FAIL reload_mem_adr got=%h exp=00000000", mem_adr); else pass_cnt++;
        total_cnt++; if (rx_ready !== 1'b1) $display("FAIL reload_rx_ready got=%b exp=1", rx_ready); else pass_cnt++;
        core_we    = 1'b0;
        core_adr   = 32'h0;
        core_wdata = 32'h0;
        clear_log();
        send(8'h00);
        send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        total_cnt++; if (done !== 1'b0) $display("FAIL zero_waits_chk got=%b exp=0", done); else pass_cnt++;
        send(8'h00);
`endif
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL zero_done got=%b exp=1", done); else pass_cnt++;
        total_cnt++; if (wr_adr.size() != 0) $display("FAIL zero_write_count got=%0d exp=0", wr_adr.size()); else pass_cnt++;
    endtask

    task automatic test_overflow();
        pulse_reload();
        clear_log();
        send(8'h01);
        send(8'h04);
        total_cnt++; if (err !== 1'b1) $display("FAIL ovf_err got=%b exp=1", err); else pass_cnt++;
        total_cnt++; if (core_reset !== 1'b1) $display("FAIL ovf_core_reset got=%b exp=1", core_reset); else pass_cnt++;
        total_cnt++; if (rx_ready !== 1'b0) $display("FAIL ovf_rx_ready got=%b exp=0", rx_ready); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL ovf_done got=%b exp=0", done); else pass_cnt++;
        send(8'hFF);
        @(negedge clk);
        total_cnt++; if (err !== 1'b1) $display("FAIL ovf_err_hold got=%b exp=1", err); else pass_cnt++;
        total_cnt++; if (wr_adr.size() != 0) $display("FAIL ovf_write_count got=%0d exp=0", wr_adr.size()); else pass_cnt++;
        pulse_reload();
        total_cnt++; if (err !== 1'b0) $display("FAIL ovf_reload_err got=%b exp=0", err); else pass_cnt++;
        total_cnt++; if (rx_ready !== 1'b1) $display("FAIL ovf_reload_rx_ready got=%b exp=1", rx_ready); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        logic [7:0] frame[$];
        int n;
        send(8'h01);
        send(8'h00);
        send(8'hAA);
        send(8'hBB);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total_cnt++; if (rx_ready !== 1'b1) $display("FAIL midrst_rx_ready got=%b exp=1", rx_ready); else pass_cnt++;
        total_cnt++; if (core_reset !== 1'b1) $display("FAIL midrst_core_reset got=%b exp=1", core_reset); else pass_cnt++;
        total_cnt++; if (mem_wdata !== 32'h0) $display("FAIL midrst_wdata got=%h exp=00000000", mem_wdata); else pass_cnt++;
        clear_log();
        frame = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef LOADER_CHECKSUM_EN
        frame.push_back(8'h45);
`endif
        foreach (frame[k]) send(frame[k]);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL midrst_done got=%b exp=1", done); else pass_cnt++;
        total_cnt++; if (wr_adr.size() != 1) $display("FAIL midrst_write_count got=%0d exp=1", wr_adr.size()); else pass_cnt++;
        if (wr_adr.size() == 1) begin
            total_cnt++; if (wr_adr[0] !== 32'h0) $display("FAIL midrst_adr got=%h exp=00000000", wr_adr[0]); else pass_cnt++;
            total_cnt++; if (wr_dat[0] !== 32'h4433_2211) $display("FAIL midrst_data got=%h exp=44332211", wr_dat[0]); else pass_cnt++;
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] frame[$];
        int n;
        frame = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
        pulse_reload();
        clear_log();
        foreach (frame[k]) send(frame[k]);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total_cnt++; if (done !== 1'b1) $display("FAIL chk_good_done got=%b exp=1", done); else pass_cnt++;
        total_cnt++; if (wr_dat.size() != 1) $display("FAIL chk_good_count got=%0d exp=1", wr_dat.size()); else pass_cnt++;
        if (wr_dat.size() == 1) begin
            total_cnt++; if (wr_dat[0] !== 32'hDEAD_BEEF) $display("FAIL chk_good_data got=%h exp=deadbeef", wr_dat[0]); else pass_cnt++;
        end
        frame[6] = 8'h24;
        pulse_reload();
        clear_log();
        foreach (frame[k]) send(frame[k]);
        n = 0;
        while (err !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total_cnt++; if (err !== 1'b1) $display("FAIL chk_bad_err got=%b exp=1", err); else pass_cnt++;
        total_cnt++; if (core_reset !== 1'b1) $display("FAIL chk_bad_core_reset got=%b exp=1", core_reset); else pass_cnt++;
        total_cnt++; if (wr_adr.size() != 1) $display("FAIL chk_bad_count got=%0d exp=1", wr_adr.size()); else pass_cnt++;
        if (wr_adr.size() == 1) begin
            total_cnt++; if (wr_adr[0] !== 32'h0) $display("FAIL chk_bad_adr got=%h exp=00000000", wr_adr[0]); else pass_cnt++;
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        reload     = 1'b0;
        core_adr   = 32'h0;
        core_we    = 1'b0;
        core_wdata = 32'h0;
        test_reset();
        test_two_words();
        test_passthrough();
        test_reload_zero();
        test_overflow();
        test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
